// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial subtractor controller.
// Steps one 1-bit subtract cell LSB-first over WIDTH enabled cycles to
// produce diff = a - b (mod 2^WIDTH) and the final borrow.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   en           clock enable; 0 freezes everything except the DONE->IDLE step
//   start, a, b  request + operands, accepted only in IDLE with en=1
//   busy         high in RUN and DONE
//   done         one-cycle pulse, diff/borrow_out valid
//   diff         registered result
//   borrow_out   registered final borrow (a < b unsigned)
//
// Optional build macro SERIAL_SUB_SAT_EN: on underflow diff loads 0
// (saturating) while borrow_out still reports 1.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sr;
  logic [CW-1:0]    cnt;
  logic             brw;

  logic             ai, bi, d, bout, last, accept, step;
  logic [WIDTH-1:0] res_nxt, diff_ld;

  // Subtract cell and control strobes
  always_comb begin
    ai      = sa[0];
    bi      = sb[0];
    d       = ai ^ bi ^ brw;
    // two cascaded half-subtract stages
    bout    = (~ai & bi) | (~(ai ^ bi) & brw);
    last    = (cnt == CW'(WIDTH - 1));
    accept  = (state == IDLE) && en && start;
    step    = (state == RUN) && en;
    res_nxt = {d, sr[WIDTH-1:1]};
`ifdef SERIAL_SUB_SAT_EN
    diff_ld = bout ? '0 : res_nxt;
`else
    diff_ld = res_nxt;
`endif
  end

  // Next state and outputs
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE:    if (accept)      state_nxt = RUN;
      RUN:     if (en && last)  state_nxt = DONE;
      DONE:                     state_nxt = IDLE;  // independent of en
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath: shift registers, borrow, counter, result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa         <= '0;
      sb         <= '0;
      sr         <= '0;
      cnt        <= '0;
      brw        <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      brw <= 1'b0;
      cnt <= '0;
    end else if (step) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= res_nxt;
      brw <= bout;
      cnt <= cnt + 1'b1;
      if (last) begin
        diff       <= diff_ld;
        borrow_out <= bout;
      end
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, en, start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;

  int errors = 0;
  int checks = 0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    int           stall_at, stall_n;
    bit           ign_busy, dstart;
    logic [W-1:0] ed;
    logic         eb;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] d, output logic bo);
    int unsigned r;
    r  = (int'(x) - int'(y) + (1 << W)) % (1 << W);
    bo = (x < y);
    d  = W'(r);
`ifdef SERIAL_SUB_SAT_EN
    if (bo) d = '0;
`endif
  endfunction

  // Issue one operation and follow it to completion
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input int stall_at, input int stall_n,
                       input bit ign_busy, input bit dstart,
                       input logic [W-1:0] ed, input logic eb);
    int n = 0, busy_cnt = 0;
    bit seen = 0;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_; en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (n < 100 && !seen) begin
      @(negedge clk);
      n++;
      if (busy) busy_cnt++;
      if (done) seen = 1;
      if (stall_n > 0 && n == stall_at + 1)
        chk("stall_frozen", {busy, done}, 2'b10);
      en = !(stall_n > 0 && n >= stall_at && n < stall_at + stall_n);
      if (ign_busy && (n == 2 || n == 4)) begin
        start = 1'b1; a = 1; b = 1;
      end else begin
        start = 1'b0;
      end
    end
    en = 1'b1;
    if (!seen) begin
      chk("timeout", 0, 1);
    end else begin
      chk("latency", n, W + 1 + stall_n);
      chk("busy_cycles", busy_cnt, n);
      chk("diff", diff, ed);
      chk("borrow", borrow_out, eb);
      if (dstart) begin
        start = 1'b1; a = 1; b = 1;   // during the DONE cycle
      end
      @(negedge clk);
      start = 1'b0;
      chk("done_one_cycle", done, 0);
      chk("idle_after", busy, 0);
      chk("diff_hold", diff, ed);
    end
  endtask

  vec_t vecs[7];

  initial begin
    logic [W-1:0] ed, ra, rb;
    logic         eb;
    int           n;

    vecs[0] = '{8'd200, 8'd55,  0, 0, 0, 0, 8'd145, 1'b0};
    vecs[1] = '{8'd5,   8'd10,  0, 0, 0, 0, 8'd251, 1'b1};
    vecs[2] = '{8'hA5,  8'hA5,  0, 0, 0, 0, 8'd0,   1'b0};
    vecs[3] = '{8'h00,  8'hFF,  0, 0, 0, 0, 8'd1,   1'b1};
    vecs[4] = '{8'd100, 8'd1,   3, 3, 0, 0, 8'd99,  1'b0};
    vecs[5] = '{8'd50,  8'd20,  0, 0, 1, 1, 8'd30,  1'b0};
    vecs[6] = '{8'd7,   8'd2,   0, 0, 0, 0, 8'd5,   1'b0};

    rst_n = 1'b0; en = 1'b1; start = 1'b1; a = 8'd3; b = 8'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {busy, done, diff, borrow_out}, 0);
    rst_n = 1'b1; start = 1'b0;

    // start with en=0 in IDLE is not accepted
    @(negedge clk); en = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0; en = 1'b1;
    chk("start_en0_ignored", busy, 0);

    foreach (vecs[i]) begin
      ed = vecs[i].ed;
`ifdef SERIAL_SUB_SAT_EN
      if (vecs[i].eb) ed = '0;
`endif
      do_op(vecs[i].a, vecs[i].b, vecs[i].stall_at, vecs[i].stall_n,
            vecs[i].ign_busy, vecs[i].dstart, ed, vecs[i].eb);
    end

    // Reset mid-RUN: a=9, b=3, reset applied as bit 4 would be processed
    @(negedge clk);
    start = 1'b1; a = 8'd9; b = 8'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_run", {busy, done, diff, borrow_out}, 0);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    chk("no_done_after_rst", n, 0);
    model(8'd9, 8'd3, ed, eb);
    do_op(8'd9, 8'd3, 0, 0, 0, 0, ed, eb);

    // Randomized operands and stalls against the model
    for (int k = 0; k < 20; k++) begin
      int sa_, sn_;
      ra  = W'($urandom);
      rb  = W'($urandom);
      if (k % 4 == 0) rb = ra;
      sn_ = (k % 3 == 0) ? int'($urandom_range(1, 3)) : 0;
      sa_ = int'($urandom_range(1, W));
      model(ra, rb, ed, eb);
      do_op(ra, rb, sa_, sn_, 0, 0, ed, eb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
